idu_issue: RTL and testbench
============================

Name: idu_issue

Overview:
- Decode/issue stage that produces the operand bundle consumed by the execute unit: `gpr_rdata1_out`, `gpr_rdata2_out`, `imm` and `EXU_mode`.
- Accepts one instruction from the fetch unit per valid/ready handshake and reads the GPR file through combinational read ports.
- Holds the decoded bundle in a single-entry output register with its own valid/ready handshake.
- Tracks in-flight destination registers in a scoreboard and stalls read-after-write hazards until the write-back unit retires them.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of GPRs (16 for RV32E).
- RAW, 5, register address width; must equal log2(NREG).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  fetch holds a valid instruction.
- inst_ready  out  1  stage accepts the instruction this cycle.
- inst  in  32  instruction word.
- rs1_addr  out  RAW  GPR read address 1, combinational = inst[19:15].
- rs2_addr  out  RAW  GPR read address 2, combinational = inst[24:20].
- rs1_data  in  XLEN  GPR read data 1, combinational.
- rs2_data  in  XLEN  GPR read data 2, combinational.
- out_valid  out  1  bundle valid toward EXU.
- out_ready  in  1  EXU consumes the bundle.
- gpr_rdata1_out  out  XLEN  registered rs1 value.
- gpr_rdata2_out  out  XLEN  registered rs2 value.
- imm  out  XLEN  sign-extended I-immediate.
- EXU_mode  out  2  bit0: 0 = src1/src2, 1 = src1/imm; bit1: 0 = add, 1 = sub.
- rd_addr  out  RAW  destination register.
- rd_wen  out  1  result must be written back.
- ebreak  out  1  instruction is ebreak.
- illegal  out  1  instruction not decoded.
- wb_valid  in  1  write-back retires a destination this cycle.
- wb_rd  in  RAW  retired destination.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0; scoreboard cleared to all zeros.
  - All registered outputs are 0, including EXU_mode=2'b00, rd_wen=0, ebreak=0 and illegal=0.
  - Reset mid-transfer discards the held bundle; no partial state survives.
- Decode (combinational on `inst`):
  - add: opcode 0110011, funct3 000, funct7 0000000 -> mode 00, uses rs1 and rs2, rd_wen=1.
  - sub: same opcode and funct3, funct7 0100000 -> mode 10, uses rs1 and rs2, rd_wen=1.
  - addi: opcode 0010011, funct3 000 -> mode 01, uses rs1 only, rd_wen=1. imm = {{20{inst[31]}}, inst[31:20]}; imm is 0 for other formats.
  - ebreak: exactly 0x00100073 -> ebreak=1, rd_wen=0, mode 00.
  - Anything else -> illegal=1, rd_wen=0, mode 00, no source used.
  - Mode 11 is never produced.
  - rd_wen is forced to 0 when rd=0.
- Hazard detection:
  - hazard = (uses_rs1 & rs1≠0 & sb[rs1]) | (uses_rs2 & rs2≠0 & sb[rs2]).
  - Checked against the registered scoreboard only; there is no bypass from the same-cycle write-back.
- Input handshake:
  - inst_ready = (!out_valid | out_ready) & !hazard.
  - inst_ready must not depend on inst_valid for the slot-free term.
  - Transfer occurs when inst_valid & inst_ready.
- On transfer:
  - The output register loads the decoded fields plus rs1_data and rs2_data.
  - out_valid=1 from the next cycle, i.e. latency one cycle.
- Output handshake:
  - A bundle is held stable while out_valid & !out_ready.
  - out_valid drops the cycle after a consume with no new transfer.
  - Consume and accept in the same cycle give back-to-back throughput of 1 per cycle.
- Scoreboard, 1 bit per register; bit 0 is always 0:
  - Set on transfer when rd_wen.
  - Cleared when wb_valid, for wb_rd.
  - Set and clear of the same index in the same cycle: set wins, because the new producer is outstanding.
  - wb_valid with wb_rd=0, or with the bit already clear, has no effect.
  - A consumer waiting on x_n becomes issuable the cycle after the wb_valid clearing x_n. The GPR file commits that write at the same edge, so the data read is fresh.
- Illegal and ebreak instructions issue normally and do not touch the scoreboard.

Decomposition:
- Shared package `npc_pkg` holds:
  - opcode constants OP=7'b0110011 and OP_IMM=7'b0010011;
  - funct7 constants F7_ADD=7'b0000000 and F7_SUB=7'b0100000;
  - EBREAK=32'h00100073;
  - EXU_mode constants MODE_RR_ADD=2'b00, MODE_RI_ADD=2'b01, MODE_RR_SUB=2'b10.
- One natural sub-module: `idu_scoreboard`, with set port, clear port and two query ports; it is NREG bits with the set-wins rule.
- Decode logic stays inline.

Test Plan:
- Reset then idle: rst_n pulsed low asynchronously mid-cycle -> out_valid=0 and inst_ready=1 immediately; all outputs 0.
- addi: inst=0x00500093 (addi x1,x0,5) with rs1_data=0 and out_ready=1 -> next cycle out_valid=1, imm=5, EXU_mode=01, rd_addr=1, rd_wen=1; sb[1]=1.
- RAW stall: after the addi, present 0x00108133 (add x2,x1,x1) -> inst_ready=0 until wb_valid=1, wb_rd=1; issues the cycle after; EXU_mode=00 with rs1_data/rs2_data=5 latched.
- sub with simultaneous set/clear: 0x401101b3 (sub x3,x2,x1) issues in the same cycle as wb_valid, wb_rd=3 -> sb[3] ends 1 and EXU_mode=10.
- Backpressure: out_ready=0 for 3 cycles with a held bundle -> outputs stable, inst_ready=0; out_ready=1 with a new inst -> consume and accept in one cycle.
- ebreak/illegal: 0x00100073 -> ebreak=1, rd_wen=0; 0xFFFFFFFF -> illegal=1, rd_wen=0; scoreboard unchanged.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared opcode, funct7 and execute-mode encodings for the decode/issue path.
package npc_pkg;
   localparam logic [6:0]  OP          = 7'b0110011;
   localparam logic [6:0]  OP_IMM      = 7'b0010011;
   localparam logic [6:0]  F7_ADD      = 7'b0000000;
   localparam logic [6:0]  F7_SUB      = 7'b0100000;
   localparam logic [31:0] EBREAK      = 32'h00100073;
   localparam logic [1:0]  MODE_RR_ADD = 2'b00;
   localparam logic [1:0]  MODE_RI_ADD = 2'b01;
   localparam logic [1:0]  MODE_RR_SUB = 2'b10;
endpackage

// File: rtl/idu_scoreboard.sv
// idu_scoreboard: one busy bit per GPR for in-flight destinations.
// A set and a clear of the same index in one cycle leave the bit set; x0 is never busy.
module idu_scoreboard #(
   parameter int NREG = 32,
   parameter int RAW  = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_set_en,
   input  logic [RAW-1:0] i_set_idx,
   input  logic           i_clr_en,
   input  logic [RAW-1:0] i_clr_idx,
   input  logic [RAW-1:0] i_q1_idx,
   input  logic [RAW-1:0] i_q2_idx,
   output logic           o_q1_busy,
   output logic           o_q2_busy
);
   logic [NREG-1:0] r_sb;
   logic [NREG-1:0] w_sb_nxt;

   always_comb begin
      w_sb_nxt = r_sb;
      if (i_clr_en) w_sb_nxt[i_clr_idx] = 1'b0;
      if (i_set_en) w_sb_nxt[i_set_idx] = 1'b1;
      w_sb_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_sb <= '0;
      else        r_sb <= w_sb_nxt;

   assign o_q1_busy = r_sb[i_q1_idx];
   assign o_q2_busy = r_sb[i_q2_idx];
endmodule

// File: rtl/idu_issue.sv
// idu_issue: decodes add/sub/addi/ebreak, reads the GPR file and issues a registered
// operand bundle to the execute unit, stalling on RAW hazards tracked by a scoreboard.
module idu_issue
   import npc_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_valid,
   output logic            inst_ready,
   input  logic [31:0]     inst,
   output logic [RAW-1:0]  rs1_addr,
   output logic [RAW-1:0]  rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] gpr_rdata1_out,
   output logic [XLEN-1:0] gpr_rdata2_out,
   output logic [XLEN-1:0] imm,
   output logic [1:0]      EXU_mode,
   output logic [RAW-1:0]  rd_addr,
   output logic            rd_wen,
   output logic            ebreak,
   output logic            illegal,
   input  logic            wb_valid,
   input  logic [RAW-1:0]  wb_rd
);
   logic            w_is_add, w_is_sub, w_is_addi, w_is_ebreak, w_is_illegal;
   logic            w_uses_rs1, w_uses_rs2, w_rd_wen, w_busy1, w_busy2, w_hazard, w_xfer;
   logic [RAW-1:0]  w_rd;
   logic [1:0]      w_mode;
   logic [XLEN-1:0] w_imm;
   logic            r_valid;

   assign rs1_addr     = inst[15 +: RAW];
   assign rs2_addr     = inst[20 +: RAW];
   assign w_rd         = inst[7 +: RAW];
   assign w_is_add     = inst[6:0] == OP && inst[14:12] == 3'b000 && inst[31:25] == F7_ADD;
   assign w_is_sub     = inst[6:0] == OP && inst[14:12] == 3'b000 && inst[31:25] == F7_SUB;
   assign w_is_addi    = inst[6:0] == OP_IMM && inst[14:12] == 3'b000;
   assign w_is_ebreak  = inst == EBREAK;
   assign w_is_illegal = !(w_is_add | w_is_sub | w_is_addi | w_is_ebreak);
   assign w_uses_rs2   = w_is_add | w_is_sub;
   assign w_uses_rs1   = w_uses_rs2 | w_is_addi;
   assign w_rd_wen     = w_uses_rs1 && w_rd != '0;
   assign w_mode       = w_is_sub ? MODE_RR_SUB : w_is_addi ? MODE_RI_ADD : MODE_RR_ADD;
   assign w_imm        = w_is_addi ? {{(XLEN-12){inst[31]}}, inst[31:20]} : '0;

   // No write-back bypass: a retiring register unblocks its consumer one cycle later.
   assign w_hazard   = (w_uses_rs1 && rs1_addr != '0 && w_busy1) ||
                       (w_uses_rs2 && rs2_addr != '0 && w_busy2);
   assign inst_ready = (!r_valid || out_ready) && !w_hazard;
   assign w_xfer     = inst_valid && inst_ready;
   assign out_valid  = r_valid;

   idu_scoreboard #(.NREG(NREG), .RAW(RAW)) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_set_en  (w_xfer && w_rd_wen),
      .i_set_idx (w_rd),
      .i_clr_en  (wb_valid),
      .i_clr_idx (wb_rd),
      .i_q1_idx  (rs1_addr),
      .i_q2_idx  (rs2_addr),
      .o_q1_busy (w_busy1),
      .o_q2_busy (w_busy2)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_valid        <= 1'b0;
         gpr_rdata1_out <= '0;
         gpr_rdata2_out <= '0;
         imm            <= '0;
         EXU_mode       <= 2'b00;
         rd_addr        <= '0;
         rd_wen         <= 1'b0;
         ebreak         <= 1'b0;
         illegal        <= 1'b0;
      end else if (w_xfer) begin
         r_valid        <= 1'b1;
         gpr_rdata1_out <= rs1_data;
         gpr_rdata2_out <= rs2_data;
         imm            <= w_imm;
         EXU_mode       <= w_mode;
         rd_addr        <= w_rd;
         rd_wen         <= w_rd_wen;
         ebreak         <= w_is_ebreak;
         illegal        <= w_is_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
endmodule

// File: tb/tb_idu_issue.sv
// tb_idu_issue: directed scenario tests for idu_issue with hand-computed expectations.
module tb_idu_issue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic [31:0] inst = 32'h0;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data = 32'h0;
   logic [31:0] rs2_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] gpr_rdata1_out, gpr_rdata2_out, imm;
   logic [1:0]  EXU_mode;
   logic [4:0]  rd_addr;
   logic        rd_wen, ebreak, illegal;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   int          n_tests = 0;
   int          n_fail = 0;

   idu_issue dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .gpr_rdata1_out(gpr_rdata1_out),
      .gpr_rdata2_out(gpr_rdata2_out), .imm(imm), .EXU_mode(EXU_mode), .rd_addr(rd_addr),
      .rd_wen(rd_wen), .ebreak(ebreak), .illegal(illegal), .wb_valid(wb_valid), .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL rst_inst_ready got %0h exp 1", inst_ready); end
      n_tests++; if (imm !== 32'h0) begin n_fail++; $display("FAIL rst_imm got %0h exp 0", imm); end
      n_tests++; if (EXU_mode !== 2'b00) begin n_fail++; $display("FAIL rst_mode got %0h exp 0", EXU_mode); end
      n_tests++; if ({rd_wen, ebreak, illegal} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %0h exp 0", {rd_wen, ebreak, illegal}); end
      n_tests++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_rd_addr got %0h exp 0", rd_addr); end
      n_tests++; if ({gpr_rdata1_out, gpr_rdata2_out} !== 64'h0) begin n_fail++; $display("FAIL rst_gpr got %0h/%0h exp 0/0", gpr_rdata1_out, gpr_rdata2_out); end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_addi();
      out_ready = 1'b1; inst_valid = 1'b1; inst = 32'h00500093; rs1_data = 32'h0; rs2_data = 32'h0;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %0h exp 1", inst_ready); end
      tick();
      inst_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_out_valid got %0h exp 1", out_valid); end
      n_tests++; if (imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %0h exp 5", imm); end
      n_tests++; if (EXU_mode !== 2'b01) begin n_fail++; $display("FAIL addi_mode got %0h exp 1", EXU_mode); end
      n_tests++; if (rd_addr !== 5'd1) begin n_fail++; $display("FAIL addi_rd got %0h exp 1", rd_addr); end
      n_tests++; if ({rd_wen, ebreak, illegal} !== 3'b100) begin n_fail++; $display("FAIL addi_flags got %0h exp 4", {rd_wen, ebreak, illegal}); end
   endtask

   task automatic test_raw_stall();
      inst_valid = 1'b1; inst = 32'h00108133; rs1_data = 32'd5; rs2_data = 32'd5;
      #1;
      n_tests++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd1}) begin n_fail++; $display("FAIL raw_addrs got %0h/%0h exp 1/1", rs1_addr, rs2_addr); end
      n_tests++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall0 got %0h exp 0", inst_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_drain got %0h exp 0", out_valid); end
      n_tests++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall1 got %0h exp 0", inst_ready); end
      wb_valid = 1'b1; wb_rd = 5'd1;
      #1;
      n_tests++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL raw_nobypass got %0h exp 0", inst_ready); end
      tick();
      wb_valid = 1'b0;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got %0h exp 1", inst_ready); end
      tick();
      inst_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_out_valid got %0h exp 1", out_valid); end
      n_tests++; if (EXU_mode !== 2'b00) begin n_fail++; $display("FAIL raw_mode got %0h exp 0", EXU_mode); end
      n_tests++; if ({gpr_rdata1_out, gpr_rdata2_out} !== {32'd5, 32'd5}) begin n_fail++; $display("FAIL raw_data got %0h/%0h exp 5/5", gpr_rdata1_out, gpr_rdata2_out); end
      n_tests++; if ({rd_addr, rd_wen} !== {5'd2, 1'b1}) begin n_fail++; $display("FAIL raw_rd got %0h/%0h exp 2/1", rd_addr, rd_wen); end
      n_tests++; if (imm !== 32'h0) begin n_fail++; $display("FAIL raw_imm got %0h exp 0", imm); end
   endtask

   task automatic test_sub_setclr();
      wb_valid = 1'b1; wb_rd = 5'd2;
      tick();
      inst_valid = 1'b1; inst = 32'h401101b3; rs1_data = 32'd7; rs2_data = 32'd2; wb_rd = 5'd3;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL sub_ready got %0h exp 1", inst_ready); end
      tick();
      inst_valid = 1'b0; wb_valid = 1'b0;
      n_tests++; if (EXU_mode !== 2'b10) begin n_fail++; $display("FAIL sub_mode got %0h exp 2", EXU_mode); end
      n_tests++; if ({gpr_rdata1_out, gpr_rdata2_out} !== {32'd7, 32'd2}) begin n_fail++; $display("FAIL sub_data got %0h/%0h exp 7/2", gpr_rdata1_out, gpr_rdata2_out); end
      n_tests++; if ({rd_addr, rd_wen} !== {5'd3, 1'b1}) begin n_fail++; $display("FAIL sub_rd got %0h/%0h exp 3/1", rd_addr, rd_wen); end
      inst = 32'h00118293;
      #1;
      n_tests++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL sub_set_wins got %0h exp 0", inst_ready); end
      wb_valid = 1'b1; wb_rd = 5'd3;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; inst_valid = 1'b1; inst = 32'hFFF00313; rs1_data = 32'h0; rs2_data = 32'h0;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got %0h exp 1", inst_ready); end
      tick();
      inst = 32'h00200393;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if ({out_valid, inst_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_vr cyc %0d got %0h exp 2", i, {out_valid, inst_ready}); end
         n_tests++; if ({imm, rd_addr} !== {32'hFFFFFFFF, 5'd6}) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %0h/%0h exp ffffffff/6", i, imm, rd_addr); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_ready got %0h exp 1", inst_ready); end
      tick();
      inst_valid = 1'b0;
      n_tests++; if ({out_valid, EXU_mode} !== 3'b101) begin n_fail++; $display("FAIL bp_b2b_vm got %0h exp 5", {out_valid, EXU_mode}); end
      n_tests++; if ({imm, rd_addr} !== {32'd2, 5'd7}) begin n_fail++; $display("FAIL bp_b2b_data got %0h/%0h exp 2/7", imm, rd_addr); end
   endtask

   task automatic test_ebreak_illegal();
      inst_valid = 1'b1; inst = 32'h00100073;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL ebreak_ready got %0h exp 1", inst_ready); end
      tick();
      n_tests++; if ({rd_wen, ebreak, illegal, EXU_mode} !== 5'b01000) begin n_fail++; $display("FAIL ebreak_flags got %0h exp 8", {rd_wen, ebreak, illegal, EXU_mode}); end
      inst = 32'hFFFFFFFF;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %0h exp 1", inst_ready); end
      tick();
      inst_valid = 1'b0;
      n_tests++; if ({rd_wen, ebreak, illegal, EXU_mode} !== 5'b00100) begin n_fail++; $display("FAIL illegal_flags got %0h exp 4", {rd_wen, ebreak, illegal, EXU_mode}); end
      n_tests++; if ({imm, rd_addr} !== {32'h0, 5'd31}) begin n_fail++; $display("FAIL illegal_fields got %0h/%0h exp 0/1f", imm, rd_addr); end
      inst = 32'h000F8093;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_no_sb got %0h exp 1", inst_ready); end
      inst = 32'h00030433;
      #1;
      n_tests++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL sb_x6_kept got %0h exp 0", inst_ready); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; inst_valid = 1'b1; inst = 32'h00500093; rs1_data = 32'h0; rs2_data = 32'h0;
      tick();
      inst_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({out_valid, rd_wen, EXU_mode} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ctl got %0h exp 0", {out_valid, rd_wen, EXU_mode}); end
      n_tests++; if ({imm, rd_addr} !== {32'h0, 5'd0}) begin n_fail++; $display("FAIL mid_rst_data got %0h/%0h exp 0/0", imm, rd_addr); end
      inst = 32'h00108133;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sb1 got %0h exp 1", inst_ready); end
      inst = 32'h00030433;
      #1;
      n_tests++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sb6 got %0h exp 1", inst_ready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      tick();
      test_addi();
      test_raw_stall();
      test_sub_setclr();
      test_backpressure();
      test_ebreak_illegal();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
